// File: rtl/gfx_regs_pkg.sv
// Shared definitions for the graphics AXI-Lite command register block:
// register offsets, bit positions, response codes and channel states.
package gfx_regs_pkg;

   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_SCRATCH = 2'd2;
   localparam logic [1:0] REG_CMD     = 2'd3;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_CLR = 1;

   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_CNT_LSB = 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_RESP
   } wr_state_e;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } rd_state_e;

endpackage

// File: rtl/gfx_cmd_fifo.sv
// Command FIFO between the register bus and the graphics core.
// Registered count, head word presented straight from the array.
module gfx_cmd_fifo #(
   parameter int CMD_W   = 10,
   parameter int FIFO_AW = 3
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               push_i,
   input  logic [CMD_W-1:0]   data_i,
   input  logic               pop_i,
   input  logic               clr_i,
   output logic [CMD_W-1:0]   head_o,
   output logic               full_o,
   output logic               empty_o,
   output logic [FIFO_AW:0]   count_o
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW-1:0] PTR_ONE  = (FIFO_AW)'(1);
   localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);

   logic [CMD_W-1:0]   mem_q [DEPTH];
   logic [FIFO_AW-1:0] wptr_q, wptr_d;
   logic [FIFO_AW-1:0] rptr_q, rptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_FULL);
   assign count_o = count_q;
   assign head_o  = mem_q[rptr_q];

   // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clr_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PTR_ONE;
         if (do_pop)  rptr_d = rptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !clr_i) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/gfx_axil_cmd_regs.sv
// AXI4-Lite responder for the graphics IP: CTRL/STATUS/SCRATCH registers
// plus a CMD push port feeding a valid/ready command stream to the core.
module gfx_axil_cmd_regs
   import gfx_regs_pkg::*;
#(
   parameter int ADDR_W  = 4,
   parameter int CMD_W   = 10,
   parameter int FIFO_AW = 3
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   output logic [CMD_W-1:0]  cmd_data,
   output logic              cmd_valid,
   input  logic              cmd_ready
);

   wr_state_e wst_q, wst_d;
   rd_state_e rst_q, rst_d;

   logic        live_q;
   logic [1:0]  awsel_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        en_q, en_d;
   logic        ovf_q, ovf_d;
   logic [31:0] scratch_q, scratch_d;
   logic [1:0]  bresp_q, bresp_d;
   logic [31:0] rdata_q, rdata_d;

   logic        aw_hs, w_hs, ar_hs, commit;
   logic [1:0]  c_sel;
   logic [31:0] c_data;
   logic [3:0]  c_strb;
   logic [31:0] status;

   logic               f_push, f_pop, f_clr;
   logic               f_full, f_empty;
   logic [FIFO_AW:0]   f_count;
   logic [CMD_W-1:0]   f_head;

   logic unused_addr_lsb;
   assign unused_addr_lsb = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   // Readies stay low while in reset and for the first cycle out of it.
   assign s_axi_awready = live_q && (wst_q == W_IDLE || wst_q == W_HAVE_W);
   assign s_axi_wready  = live_q && (wst_q == W_IDLE || wst_q == W_HAVE_AW);
   assign s_axi_bvalid  = (wst_q == W_RESP);
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = live_q && (rst_q == R_IDLE);
   assign s_axi_rvalid  = (rst_q == R_RESP);
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = RESP_OKAY;

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid && s_axi_wready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;

   assign c_sel  = aw_hs ? s_axi_awaddr[3:2] : awsel_q;
   assign c_data = w_hs ? s_axi_wdata : wdata_q;
   assign c_strb = w_hs ? s_axi_wstrb : wstrb_q;

   assign cmd_valid = en_q && !f_empty;
   assign cmd_data  = f_head;
   assign f_pop     = cmd_valid && cmd_ready;

   always_comb begin
      status = '0;
      status[ST_EMPTY] = f_empty;
      status[ST_FULL]  = f_full;
      status[ST_OVF]   = ovf_q;
      status[ST_CNT_LSB +: FIFO_AW+1] = f_count;
   end

   always_comb begin
      wst_d  = wst_q;
      commit = 1'b0;
      unique case (wst_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               wst_d  = W_RESP;
               commit = 1'b1;
            end else if (aw_hs) begin
               wst_d = W_HAVE_AW;
            end else if (w_hs) begin
               wst_d = W_HAVE_W;
            end
         end
         W_HAVE_AW: begin
            if (w_hs) begin
               wst_d  = W_RESP;
               commit = 1'b1;
            end
         end
         W_HAVE_W: begin
            if (aw_hs) begin
               wst_d  = W_RESP;
               commit = 1'b1;
            end
         end
         W_RESP: begin
            if (s_axi_bready) wst_d = W_IDLE;
         end
         default: wst_d = W_IDLE;
      endcase
   end

   always_comb begin
      en_d      = en_q;
      ovf_d     = ovf_q;
      scratch_d = scratch_q;
      bresp_d   = bresp_q;
      f_push    = 1'b0;
      f_clr     = 1'b0;
      if (commit) begin
         bresp_d = RESP_OKAY;
         unique case (c_sel)
            REG_CTRL: begin
               en_d  = c_data[CTRL_EN];
               f_clr = c_data[CTRL_CLR];
            end
            REG_STATUS: begin
               if (c_data[ST_OVF]) ovf_d = 1'b0;
            end
            REG_SCRATCH: begin
               for (int b = 0; b < 4; b++)
                  if (c_strb[b]) scratch_d[8*b +: 8] = c_data[8*b +: 8];
            end
            REG_CMD: begin
               if (f_full && !f_pop) begin
                  ovf_d   = 1'b1;
                  bresp_d = RESP_SLVERR;
               end else begin
                  f_push = 1'b1;
               end
            end
            default: bresp_d = RESP_OKAY;
         endcase
      end
   end

   always_comb begin
      rst_d   = rst_q;
      rdata_d = rdata_q;
      unique case (rst_q)
         R_IDLE: begin
            if (ar_hs) begin
               rst_d   = R_RESP;
               rdata_d = '0;
               unique case (s_axi_araddr[3:2])
                  REG_CTRL:    rdata_d[CTRL_EN] = en_q;
                  REG_STATUS:  rdata_d = status;
                  REG_SCRATCH: rdata_d = scratch_q;
                  default:     rdata_d = '0;
               endcase
            end
         end
         R_RESP: begin
            if (s_axi_rready) rst_d = R_IDLE;
         end
         default: rst_d = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wst_q     <= W_IDLE;
         rst_q     <= R_IDLE;
         live_q    <= 1'b0;
         awsel_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         en_q      <= 1'b0;
         ovf_q     <= 1'b0;
         scratch_q <= '0;
         bresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         wst_q     <= wst_d;
         rst_q     <= rst_d;
         live_q    <= 1'b1;
         if (aw_hs) awsel_q <= s_axi_awaddr[3:2];
         if (w_hs) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
         end
         en_q      <= en_d;
         ovf_q     <= ovf_d;
         scratch_q <= scratch_d;
         bresp_q   <= bresp_d;
         rdata_q   <= rdata_d;
      end
   end

   gfx_cmd_fifo #(
      .CMD_W   (CMD_W),
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk_i   (aclk),
      .rst_ni  (aresetn),
      .push_i  (f_push),
      .data_i  (c_data[CMD_W-1:0]),
      .pop_i   (f_pop),
      .clr_i   (f_clr),
      .head_o  (f_head),
      .full_o  (f_full),
      .empty_o (f_empty),
      .count_o (f_count)
   );

endmodule
